// File: rtl/sdram_rw_scheduler.sv
// Round-robin write/read burst scheduler sitting in front of sdram_core.
// Optional watchdog enabled by defining SDRAM_SCHED_TIMEOUT_EN.
module sdram_rw_scheduler #(
    parameter int unsigned ADDR_WIDTH    = 24,
    parameter int unsigned BURST_WIDTH   = 10,
    parameter int unsigned LEVEL_WIDTH   = 11,
    parameter int unsigned BURST_LEN     = 256,
    parameter int unsigned RD_FIFO_DEPTH = 1024,
    parameter int unsigned REGION_BASE   = 0,
    parameter int unsigned REGION_LEN    = 24'h100000,
    parameter int unsigned TIMEOUT_CYC   = 4095
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LEVEL_WIDTH-1:0] wr_fifo_level,
    input  logic [LEVEL_WIDTH-1:0] rd_fifo_level,
    input  logic                   rd_enable,
    input  logic                   wr_ptr_clr,
    input  logic                   rd_ptr_clr,
    output logic                   wr_fifo_rd_en,
    output logic                   rd_fifo_wr_en,
    output logic                   wr_burst_req,
    output logic [BURST_WIDTH-1:0] wr_burst_len,
    output logic [ADDR_WIDTH-1:0]  wr_burst_addr,
    input  logic                   wr_burst_data_req,
    input  logic                   wr_burst_finish,
    output logic                   rd_burst_req,
    output logic [BURST_WIDTH-1:0] rd_burst_len,
    output logic [ADDR_WIDTH-1:0]  rd_burst_addr,
    input  logic                   rd_burst_data_valid,
    input  logic                   rd_burst_finish,
    output logic                   busy,
    output logic                   sched_err
);

    localparam int unsigned LW1 = LEVEL_WIDTH + 1;
    localparam int unsigned AW1 = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(REGION_BASE);
    localparam logic [AW1-1:0]        LIMIT = AW1'(REGION_BASE + REGION_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_WAIT,
        S_RD_REQ,
        S_RD_WAIT
    } state_e;

    state_e                  state_q, state_d;
    logic                    wr_req_q, wr_req_d;
    logic                    rd_req_q, rd_req_d;
    logic                    busy_q, busy_d;
    logic                    last_wr_q, last_wr_d;
    logic                    wr_pend_q, wr_pend_d;
    logic                    rd_pend_q, rd_pend_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic                    wr_elig_c, rd_elig_c;
    logic                    wr_in_burst_c, rd_in_burst_c;
    logic                    timeout_c;

    // Advance a pointer by one burst, wrapping inside the region.
    function automatic logic [ADDR_WIDTH-1:0] ptr_next(input logic [ADDR_WIDTH-1:0] p);
        logic [AW1-1:0] sum;
        sum = {1'b0, p} + AW1'(BURST_LEN);
        return (sum >= LIMIT) ? BASE : sum[ADDR_WIDTH-1:0];
    endfunction

    assign wr_elig_c = ({1'b0, wr_fifo_level} >= LW1'(BURST_LEN));
    assign rd_elig_c = rd_enable &&
                       (({1'b0, rd_fifo_level} + LW1'(BURST_LEN)) <= LW1'(RD_FIFO_DEPTH));
    assign wr_in_burst_c = (state_q == S_WR_REQ) || (state_q == S_WR_WAIT);
    assign rd_in_burst_c = (state_q == S_RD_REQ) || (state_q == S_RD_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wr_req_q  <= 1'b0;
            rd_req_q  <= 1'b0;
            busy_q    <= 1'b0;
            last_wr_q <= 1'b0;
            wr_pend_q <= 1'b0;
            rd_pend_q <= 1'b0;
            wr_ptr_q  <= BASE;
            rd_ptr_q  <= BASE;
        end else begin
            state_q   <= state_d;
            wr_req_q  <= wr_req_d;
            rd_req_q  <= rd_req_d;
            busy_q    <= busy_d;
            last_wr_q <= last_wr_d;
            wr_pend_q <= wr_pend_d;
            rd_pend_q <= rd_pend_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_req_d  = wr_req_q;
        rd_req_d  = rd_req_q;
        last_wr_d = last_wr_q;
        wr_pend_d = wr_pend_q;
        rd_pend_d = rd_pend_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;

        // A clear during its own burst is deferred so the address stays stable.
        if (wr_in_burst_c) begin
            if (wr_ptr_clr) wr_pend_d = 1'b1;
        end else if (wr_ptr_clr || wr_pend_q) begin
            wr_ptr_d  = BASE;
            wr_pend_d = 1'b0;
        end
        if (rd_in_burst_c) begin
            if (rd_ptr_clr) rd_pend_d = 1'b1;
        end else if (rd_ptr_clr || rd_pend_q) begin
            rd_ptr_d  = BASE;
            rd_pend_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (wr_elig_c && (!rd_elig_c || !last_wr_q)) begin
                    state_d   = S_WR_REQ;
                    wr_req_d  = 1'b1;
                    last_wr_d = 1'b1;
                end else if (rd_elig_c) begin
                    state_d   = S_RD_REQ;
                    rd_req_d  = 1'b1;
                    last_wr_d = 1'b0;
                end
            end
            S_WR_REQ: begin
                if (wr_burst_data_req) begin
                    state_d  = S_WR_WAIT;
                    wr_req_d = 1'b0;
                end
            end
            S_WR_WAIT: begin
                if (wr_burst_finish) begin
                    state_d   = S_IDLE;
                    wr_ptr_d  = (wr_ptr_clr || wr_pend_q) ? BASE : ptr_next(wr_ptr_q);
                    wr_pend_d = 1'b0;
                end
            end
            S_RD_REQ: begin
                if (rd_burst_data_valid) begin
                    state_d  = S_RD_WAIT;
                    rd_req_d = 1'b0;
                end
            end
            S_RD_WAIT: begin
                if (rd_burst_finish) begin
                    state_d   = S_IDLE;
                    rd_ptr_d  = (rd_ptr_clr || rd_pend_q) ? BASE : ptr_next(rd_ptr_q);
                    rd_pend_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (timeout_c) begin
            state_d  = S_IDLE;
            wr_req_d = 1'b0;
            rd_req_d = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

`ifdef SDRAM_SCHED_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] tmo_cnt_q;
    logic             err_q;

    // Cycles spent outside IDLE; a stuck burst is abandoned after TIMEOUT_CYC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= (state_q == S_IDLE) ? '0 : tmo_cnt_q + CNT_W'(1);
            if (timeout_c) err_q <= 1'b1;
        end
    end

    assign timeout_c = (state_q != S_IDLE) && (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign sched_err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC == 0);
    assign timeout_c      = 1'b0;
    assign sched_err      = 1'b0;
`endif

    assign wr_fifo_rd_en = wr_burst_data_req;
    assign rd_fifo_wr_en = rd_burst_data_valid;
    assign wr_burst_req  = wr_req_q;
    assign rd_burst_req  = rd_req_q;
    assign wr_burst_addr = wr_ptr_q;
    assign rd_burst_addr = rd_ptr_q;
    assign wr_burst_len  = BURST_WIDTH'(BURST_LEN);
    assign rd_burst_len  = BURST_WIDTH'(BURST_LEN);
    assign busy          = busy_q;

endmodule

// File: tb/tb_sdram_rw_scheduler.sv
// Scoreboard bench for sdram_rw_scheduler with a simple sdram_core responder.
module tb_sdram_rw_scheduler;

    localparam int unsigned BL       = 256;
    localparam int unsigned RLEN     = 1024;
    localparam int unsigned DEPTH    = 1024;
    localparam int unsigned TMO      = 100;
    localparam int unsigned DATA_CYC = 2;

    typedef struct {
        logic        is_wr;
        logic [23:0] addr;
        logic        lat_chk;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] wr_fifo_level = '0;
    logic [10:0] rd_fifo_level = '0;
    logic        rd_enable = 1'b0;
    logic        wr_ptr_clr = 1'b0;
    logic        rd_ptr_clr = 1'b0;
    logic        wr_fifo_rd_en, rd_fifo_wr_en;
    logic        wr_burst_req, rd_burst_req;
    logic [9:0]  wr_burst_len, rd_burst_len;
    logic [23:0] wr_burst_addr, rd_burst_addr;
    logic        wr_burst_data_req = 1'b0;
    logic        wr_burst_finish = 1'b0;
    logic        rd_burst_data_valid = 1'b0;
    logic        rd_burst_finish = 1'b0;
    logic        busy, sched_err;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   busy_cnt = 0;
    exp_t sb[$];

    logic        core_busy = 1'b0;
    logic        core_holding = 1'b0;
    logic        hold_fin = 1'b0;
    logic        clr_with_fin = 1'b0;
    logic [23:0] m_wr = '0;
    logic [23:0] m_rd = '0;
    logic        m_last_wr = 1'b0;

    sdram_rw_scheduler #(
        .REGION_LEN (RLEN),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .wr_fifo_level      (wr_fifo_level),
        .rd_fifo_level      (rd_fifo_level),
        .rd_enable          (rd_enable),
        .wr_ptr_clr         (wr_ptr_clr),
        .rd_ptr_clr         (rd_ptr_clr),
        .wr_fifo_rd_en      (wr_fifo_rd_en),
        .rd_fifo_wr_en      (rd_fifo_wr_en),
        .wr_burst_req       (wr_burst_req),
        .wr_burst_len       (wr_burst_len),
        .wr_burst_addr      (wr_burst_addr),
        .wr_burst_data_req  (wr_burst_data_req),
        .wr_burst_finish    (wr_burst_finish),
        .rd_burst_req       (rd_burst_req),
        .rd_burst_len       (rd_burst_len),
        .rd_burst_addr      (rd_burst_addr),
        .rd_burst_data_valid(rd_burst_data_valid),
        .rd_burst_finish    (rd_burst_finish),
        .busy               (busy),
        .sched_err          (sched_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] nxt(input logic [23:0] p);
        return (32'(p) + BL >= RLEN) ? 24'd0 : p + 24'(BL);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        wr_fifo_level = '0;
        rd_fifo_level = '0;
        rd_enable = 1'b0;
        sb.delete();
        m_wr = '0;
        m_rd = '0;
        m_last_wr = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_wr_req", 32'(wr_burst_req), 0);
        check("rst_rd_req", 32'(rd_burst_req), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(sched_err), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("burst_len", 32'({wr_burst_len, rd_burst_len}), 32'({10'd256, 10'd256}));
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 3000; k++) begin
            if (!busy && !core_busy) break;
            @(negedge clk);
        end
        check("idle_reached", 32'(busy | core_busy), 0);
    endtask

    // Push n expected bursts from the reference model, then drive levels until they appear.
    task automatic run_bursts(input int n, input logic [10:0] wlvl, input logic [10:0] rlvl,
                              input logic ren);
        logic wr_e, rd_e, dir;
        wr_e = (32'(wlvl) >= BL);
        rd_e = ren && (32'(rlvl) + BL <= DEPTH);
        for (int i = 0; i < n; i++) begin
            dir = (wr_e && rd_e) ? !m_last_wr : wr_e;
            sb.push_back('{is_wr: dir, addr: dir ? m_wr : m_rd, lat_chk: (i == 0)});
            if (dir) m_wr = nxt(m_wr);
            else     m_rd = nxt(m_rd);
            m_last_wr = dir;
        end
        start_cyc = cyc;
        wr_fifo_level = wlvl;
        rd_fifo_level = rlvl;
        rd_enable = ren;
        for (int k = 0; k < 4000; k++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check("sb_drain", 32'(sb.size()), 0);
        sb.delete();
        wr_fifo_level = '0;
        rd_fifo_level = '0;
        rd_enable = 1'b0;
        wait_idle();
    endtask

    // Start one write burst at the model pointer and park the core before finish.
    task automatic start_held_wr();
        hold_fin = 1'b1;
        sb.push_back('{is_wr: 1'b1, addr: m_wr, lat_chk: 1'b1});
        m_last_wr = 1'b1;
        start_cyc = cyc;
        wr_fifo_level = 11'(BL);
        for (int k = 0; k < 200; k++) begin
            if (core_holding) break;
            @(negedge clk);
        end
        check("hold_reached", 32'(core_holding), 1);
        wr_fifo_level = '0;
    endtask

    task automatic serve(input logic is_wr);
        int stall;
        stall = $urandom_range(1, 3);
        core_busy = 1'b1;
        repeat (stall) @(negedge clk);
        check("req_held", 32'(is_wr ? wr_burst_req : rd_burst_req), 1);
        for (int i = 0; i < DATA_CYC; i++) begin
            if (is_wr) wr_burst_data_req = 1'b1;
            else       rd_burst_data_valid = 1'b1;
            #1;
            check("fifo_strobe", 32'(is_wr ? wr_fifo_rd_en : rd_fifo_wr_en), 1);
            @(negedge clk);
            if (i == 0) check("req_drop", 32'(is_wr ? wr_burst_req : rd_burst_req), 0);
        end
        wr_burst_data_req = 1'b0;
        rd_burst_data_valid = 1'b0;
        core_holding = 1'b1;
        while (hold_fin) @(negedge clk);
        core_holding = 1'b0;
        if (is_wr) wr_burst_finish = 1'b1;
        else       rd_burst_finish = 1'b1;
        if (clr_with_fin) wr_ptr_clr = 1'b1;
        @(negedge clk);
        wr_burst_finish = 1'b0;
        rd_burst_finish = 1'b0;
        if (clr_with_fin) wr_ptr_clr = 1'b0;
        check("busy_end", 32'(busy), 0);
        core_busy = 1'b0;
    endtask

    // sdram_core responder
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && !core_busy && (wr_burst_req || rd_burst_req)) serve(wr_burst_req);
        end
    end

    // Output monitor: pops one expectation per request rising edge.
    initial begin
        logic pw, pr;
        exp_t e;
        pw = 1'b0;
        pr = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (wr_burst_req || rd_burst_req)
                    check("req_excl", 32'(wr_burst_req & rd_burst_req), 0);
                if ((wr_burst_req && !pw) || (rd_burst_req && !pr)) begin
                    if (sb.size() == 0) begin
                        check("sb_unexpected", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("dir", 32'(wr_burst_req), 32'(e.is_wr));
                        check("addr", 32'(wr_burst_req ? wr_burst_addr : rd_burst_addr),
                              32'(e.addr));
                        if (e.lat_chk) check("req_lat", 32'(cyc - start_cyc), 1);
                    end
                end
            end
            pw = wr_burst_req;
            pr = rd_burst_req;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        do_reset();

        // basic write, then confirm pointer advanced by one burst
        run_bursts(1, 11'd256, 11'd0, 1'b0);
        run_bursts(1, 11'd256, 11'd0, 1'b0);
        wr_fifo_level = 11'd255;
        repeat (20) @(negedge clk);
        check("wr_gate_255", 32'(busy), 0);
        wr_fifo_level = '0;

        // round robin from reset: WR, RD, WR, RD
        do_reset();
        run_bursts(4, 11'd256, 11'd0, 1'b1);

        // wrap over a 1024-word region
        do_reset();
        run_bursts(5, 11'd256, 11'd0, 1'b0);

        // read gating
        do_reset();
        rd_enable = 1'b1;
        rd_fifo_level = 11'd769;
        repeat (20) @(negedge clk);
        check("rd_gate_769", 32'({busy, rd_burst_req}), 0);
        rd_enable = 1'b0;
        rd_fifo_level = 11'd0;
        repeat (20) @(negedge clk);
        check("rd_gate_disabled", 32'({busy, rd_burst_req}), 0);
        run_bursts(1, 11'd0, 11'd768, 1'b1);
        run_bursts(1, 11'd0, 11'd768, 1'b1);

        // pointer clears: mid-burst, coincident with finish, and in idle
        do_reset();
        run_bursts(2, 11'd256, 11'd0, 1'b0);
        start_held_wr();
        @(negedge clk);
        wr_ptr_clr = 1'b1;
        @(negedge clk);
        wr_ptr_clr = 1'b0;
        hold_fin = 1'b0;
        wait_idle();
        m_wr = '0;
        run_bursts(1, 11'd256, 11'd0, 1'b0);
        start_held_wr();
        clr_with_fin = 1'b1;
        hold_fin = 1'b0;
        wait_idle();
        clr_with_fin = 1'b0;
        m_wr = '0;
        run_bursts(1, 11'd256, 11'd0, 1'b0);
        @(negedge clk);
        wr_ptr_clr = 1'b1;
        @(negedge clk);
        wr_ptr_clr = 1'b0;
        m_wr = '0;
        run_bursts(1, 11'd256, 11'd0, 1'b0);

`ifdef SDRAM_SCHED_TIMEOUT_EN
        // watchdog: finish withheld
        do_reset();
        busy_cnt = 0;
        start_held_wr();
        for (int k = 0; k < 1000; k++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check("tmo_busy_cycles", 32'(busy_cnt), TMO);
        check("tmo_err", 32'(sched_err), 1);
        check("tmo_req", 32'(wr_burst_req), 0);
        hold_fin = 1'b0;
        wait_idle();
        run_bursts(1, 11'd256, 11'd0, 1'b0);
        check("tmo_err_sticky", 32'(sched_err), 1);
        do_reset();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
